usb_bit_timer: RTL and testbench

USB_BIT_TIMER -- requirements
Module: usb_bit_timer

---
 rtl/usb_bit_timer.sv | 103 ++++++++++
 tb/tb_usb_bit_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bit_timer.sv
// USB bit timer: divides the system clock into bit times, tracks the data-bit
// position within a byte (skipping stuffed bits), counts bytes and flags packet end.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int BITS_PER_BYTE = 8,
    parameter int ALMOST_BITS   = 1,
    parameter int BYTE_CNT_W    = 7
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             timer_en,
    input  logic                             clear,
    input  logic                             bit_stuff_en,
    input  logic [BYTE_CNT_W-1:0]            num_bytes,
    output logic                             bit_strobe,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_index,
    output logic                             byte_almost_complete,
    output logic                             byte_complete,
    output logic [BYTE_CNT_W-1:0]            byte_count,
    output logic                             packet_done
);

    localparam int PH_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(BITS_PER_BYTE);

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BITS_PER_BYTE - 1);
    localparam logic [IDX_W-1:0] IDX_ALMOST = IDX_W'(BITS_PER_BYTE - ALMOST_BITS);

    logic [PH_W-1:0]       r_phase;
    logic [IDX_W-1:0]      r_bit_index;
    logic [BYTE_CNT_W-1:0] r_byte_count;
    logic                  r_packet_done;
    logic                  r_bit_strobe;
    logic                  r_almost;
    logic                  r_complete;

    logic                  w_run;
    logic                  w_wrap;
    logic                  w_last_bit;
    logic [IDX_W-1:0]      w_idx_next;
    logic [BYTE_CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_run      = timer_en && !r_packet_done;
        w_wrap     = w_run && (r_phase == PH_LAST);
        w_last_bit = (r_bit_index == IDX_LAST);
        w_idx_next = r_bit_index + 1'b1;
        w_cnt_next = r_byte_count + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase       <= '0;
            r_bit_index   <= '0;
            r_byte_count  <= '0;
            r_packet_done <= 1'b0;
            r_bit_strobe  <= 1'b0;
            r_almost      <= 1'b0;
            r_complete    <= 1'b0;
        end else if (clear) begin
            r_phase       <= '0;
            r_bit_index   <= '0;
            r_byte_count  <= '0;
            r_packet_done <= 1'b0;
            r_bit_strobe  <= 1'b0;
            r_almost      <= 1'b0;
            r_complete    <= 1'b0;
        end else begin
            r_bit_strobe <= 1'b0;
            r_almost     <= 1'b0;
            r_complete   <= 1'b0;
            if (w_wrap) begin
                r_phase      <= '0;
                r_bit_strobe <= 1'b1;
                // A stuffed bit still takes a bit time but is not a data bit.
                if (!bit_stuff_en) begin
                    if (w_last_bit) begin
                        r_bit_index  <= '0;
                        r_complete   <= 1'b1;
                        r_byte_count <= w_cnt_next;
                        if ((num_bytes != '0) && (w_cnt_next == num_bytes))
                            r_packet_done <= 1'b1;
                    end else begin
                        r_bit_index <= w_idx_next;
                        if (w_idx_next == IDX_ALMOST)
                            r_almost <= 1'b1;
                    end
                end
            end else if (w_run) begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign bit_strobe           = r_bit_strobe;
    assign bit_index            = r_bit_index;
    assign byte_almost_complete = r_almost;
    assign byte_complete        = r_complete;
    assign byte_count           = r_byte_count;
    assign packet_done          = r_packet_done;

endmodule

// File: tb/tb_usb_bit_timer.sv
// Testbench for usb_bit_timer: default and swept instances share stimulus and are
// compared every cycle against an arithmetic model of bit/byte progression.
module tb_usb_bit_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       timer_en;
    logic       clear;
    logic       bit_stuff_en;
    logic [6:0] num_bytes;

    logic       a_strobe, a_almost, a_cmp, a_done;
    logic [2:0] a_idx;
    logic [6:0] a_cnt;
    logic       b_strobe, b_almost, b_cmp, b_done;
    logic [3:0] b_idx;
    logic [6:0] b_cnt;

    always #5 clk = ~clk;

    usb_bit_timer #(
        .CLKS_PER_BIT(8), .BITS_PER_BYTE(8), .ALMOST_BITS(1), .BYTE_CNT_W(7)
    ) u_dut_a (
        .clk(clk), .n_rst(n_rst), .timer_en(timer_en), .clear(clear),
        .bit_stuff_en(bit_stuff_en), .num_bytes(num_bytes),
        .bit_strobe(a_strobe), .bit_index(a_idx), .byte_almost_complete(a_almost),
        .byte_complete(a_cmp), .byte_count(a_cnt), .packet_done(a_done)
    );

    usb_bit_timer #(
        .CLKS_PER_BIT(2), .BITS_PER_BYTE(16), .ALMOST_BITS(3), .BYTE_CNT_W(7)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst), .timer_en(timer_en), .clear(clear),
        .bit_stuff_en(bit_stuff_en), .num_bytes(num_bytes),
        .bit_strobe(b_strobe), .bit_index(b_idx), .byte_almost_complete(b_almost),
        .byte_complete(b_cmp), .byte_count(b_cnt), .packet_done(b_done)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase in cycles, total data bits since clear; index and byte count derive from it.
    int m_clks [2] = '{8, 2};
    int m_bpb  [2] = '{8, 16};
    int m_alm  [2] = '{1, 3};
    int m_phase[2];
    int m_dbits[2];
    int m_done [2];
    int m_strb [2];
    int m_almo [2];
    int m_cmpl [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_dbits[k] = 0; m_done[k] = 0;
            m_strb[k] = 0;  m_almo[k] = 0;  m_cmpl[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        m_strb[k] = 0; m_almo[k] = 0; m_cmpl[k] = 0;
        if (clear) begin
            m_phase[k] = 0; m_dbits[k] = 0; m_done[k] = 0;
        end else if (timer_en && m_done[k] == 0) begin
            m_phase[k]++;
            if (m_phase[k] == m_clks[k]) begin
                m_phase[k] = 0;
                m_strb[k]  = 1;
                if (!bit_stuff_en) begin
                    m_dbits[k]++;
                    if (m_dbits[k] % m_bpb[k] == m_bpb[k] - m_alm[k]) m_almo[k] = 1;
                    if (m_dbits[k] % m_bpb[k] == 0) begin
                        m_cmpl[k] = 1;
                        if (num_bytes != 0 && (m_dbits[k] / m_bpb[k]) % 128 == int'(num_bytes))
                            m_done[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("a.strobe", a_strobe, m_strb[0]);
        check_val("a.index",  a_idx,    m_dbits[0] % 8);
        check_val("a.almost", a_almost, m_almo[0]);
        check_val("a.cmpl",   a_cmp,    m_cmpl[0]);
        check_val("a.count",  a_cnt,    (m_dbits[0] / 8) % 128);
        check_val("a.done",   a_done,   m_done[0]);
        check_val("b.strobe", b_strobe, m_strb[1]);
        check_val("b.index",  b_idx,    m_dbits[1] % 16);
        check_val("b.almost", b_almost, m_almo[1]);
        check_val("b.cmpl",   b_cmp,    m_cmpl[1]);
        check_val("b.count",  b_cnt,    (m_dbits[1] / 16) % 128);
        check_val("b.done",   b_done,   m_done[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1 check_all();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic async_reset();
        #2 n_rst = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    int first;
    int n;

    initial begin
        n_rst = 1'b0; timer_en = 1'b0; clear = 1'b0; bit_stuff_en = 1'b0; num_bytes = '0;
        model_reset();
        #2 check_all();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Steady run: strobe every 8 cycles, one byte per 8 strobes.
        timer_en = 1'b1;
        first = -1; n = 0;
        for (int t = 1; t <= 512; t++) begin
            tick();
            if (a_strobe && first < 0) first = t;
            if (a_cmp) n++;
        end
        check_val("steady.first_strobe", first, 8);
        check_val("steady.bytes", n, 8);
        check_val("steady.count", a_cnt, 8);

        // Stuffed 4th bit: index holds at 3, byte completes on 9th strobe.
        do_clear();
        first = -1;
        for (int t = 1; t <= 80; t++) begin
            bit_stuff_en = (t == 32);
            tick();
            if (t == 32) check_val("stuff.index", a_idx, 3);
            if (a_cmp && first < 0) first = t;
        end
        bit_stuff_en = 1'b0;
        check_val("stuff.cmpl_tick", first, 72);

        // Packet end after 2 bytes, then no further strobes.
        do_clear();
        num_bytes = 7'd2;
        first = -1; n = 0;
        for (int t = 1; t <= 168; t++) begin
            tick();
            if (a_done && first < 0) first = t;
            if (t > 128 && a_strobe) n++;
        end
        check_val("packet.done_tick", first, 128);
        check_val("packet.extra_strobes", n, 0);
        check_val("packet.count", a_cnt, 2);
        num_bytes = '0;

        // Pause at phase 5 for 10 cycles; strobe 3 enabled cycles after resume.
        do_clear();
        repeat (5) tick();
        timer_en = 1'b0;
        repeat (10) tick();
        timer_en = 1'b1;
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (a_strobe) first = t;
        end
        check_val("pause.resume_latency", first, 3);

        // Clear coincident with a wrap edge.
        n = 0;
        while (m_phase[0] != 7 && n < 16) begin tick(); n++; end
        check_val("clrwrap.reached_phase", m_phase[0], 7);
        do_clear();
        check_val("clrwrap.strobe", a_strobe, 0);
        check_val("clrwrap.index", a_idx, 0);
        tick();
        check_val("clrwrap.next_strobe", a_strobe, 0);

        // Async reset at bit_index 6, then restart from zero.
        do_clear();
        n = 0;
        while (m_dbits[0] % 8 != 6 && n < 100) begin tick(); n++; end
        check_val("rst.reached_index", a_idx, 6);
        async_reset();
        check_val("rst.index_zero", a_idx, 0);
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (a_strobe) first = t;
        end
        check_val("rst.first_strobe", first, 8);
        check_val("rst.index_one", a_idx, 1);

        // Randomized traffic against the model.
        for (int t = 0; t < 4000; t++) begin
            timer_en     = ($urandom_range(0, 9) < 8);
            bit_stuff_en = ($urandom_range(0, 9) == 0);
            clear        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) num_bytes = 7'($urandom_range(0, 4));
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
